// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider: FSM states and default width.
package div_pkg;
  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_e;
endpackage

// File: rtl/seq_divider_if.sv
// Request/result bundle between a divider client (master) and the divider (slave).
interface seq_divider_if
  import div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract, keep or restore.
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH:0]   rem_o,
  output logic             qbit_o
);
  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] trial;

  // One extra bit above the partial remainder carries the sign of the trial subtraction.
  always_comb begin
    shifted = {rem_i, bit_i};
    trial   = shifted - {2'b00, divisor_i};
    qbit_o  = ~trial[WIDTH+1];
    rem_o   = qbit_o ? trial[WIDTH:0] : shifted[WIDTH:0];
  end
endmodule

// File: rtl/seq_divider.sv
// Fixed-latency unsigned divider: WIDTH restoring iterations, one quotient bit per cycle, MSB first.
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic          clk,
  input  logic          rst_n,
  seq_divider_if.slave  bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;   // dividend bits out at MSB, quotient bits in at LSB
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rmd_q, rmd_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   step_rem;
  logic             step_qbit;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (rem_q),
    .bit_i     (dvd_q[WIDTH-1]),
    .divisor_i (dvs_q),
    .rem_o     (step_rem),
    .qbit_o    (step_qbit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      quo_q   <= '0;
      rmd_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      quo_q   <= quo_d;
      rmd_q   <= rmd_d;
      dbz_q   <= dbz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    quo_d   = quo_q;
    rmd_d   = rmd_q;
    dbz_d   = dbz_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          dvd_d = bus.dividend;
          dvs_d = bus.divisor;
          rem_d = '0;
          cnt_d = '0;
          if (bus.divisor == '0) begin
            // Zero divisor skips iteration and publishes its fixed result directly.
            state_d = DONE;
            quo_d   = '1;
            rmd_d   = bus.dividend;
            dbz_d   = 1'b1;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        rem_d = step_rem;
        dvd_d = {dvd_q[WIDTH-2:0], step_qbit};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) begin
          state_d = DONE;
          cnt_d   = '0;
          quo_d   = {dvd_q[WIDTH-2:0], step_qbit};
          rmd_d   = step_rem[WIDTH-1:0];
          dbz_d   = 1'b0;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy        = (state_q == RUN);
  assign bus.done        = (state_q == DONE);
  assign bus.quotient    = quo_q;
  assign bus.remainder   = rmd_q;
  assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed cases plus a randomized sweep against an arithmetic model.
module tb_seq_divider;
  import div_pkg::*;

  localparam int W = DEF_WIDTH;
  localparam logic [W-1:0] MAXV = '1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;

  seq_divider_if #(.WIDTH(W)) bus ();

  seq_divider #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Arithmetic reference: plain / and %, with the defined divide-by-zero result.
  function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output logic z);
    if (b == '0) begin
      q = MAXV; r = a; z = 1'b1;
    end else begin
      q = a / b; r = a % b; z = 1'b0;
    end
  endfunction

  // Present one request for exactly one edge, then scramble the operands.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    bus.start = 1'b1; bus.dividend = a; bus.divisor = b;
    tick();
    bus.start = 1'b0;
    bus.dividend = W'($urandom);
    bus.divisor  = W'($urandom);
  endtask

  // Cycles after the accepting edge until done, bounded; counts busy cycles on the way.
  task automatic wait_done(output int lat, output int nbusy);
    lat = 0; nbusy = 0;
    while (bus.done !== 1'b1 && lat < 4*W) begin
      if (bus.busy === 1'b1) nbusy++;
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
    rst_n = 1'b0;
    tick(); tick();
    n_tests++;
    if ({bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: busy=%b done=%b q=%0d r=%0d dbz=%b, all must be 0",
               bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_known();
    logic [W-1:0] at [4] = '{8'd100, 8'd255, 8'd5, 8'd255};
    logic [W-1:0] bt [4] = '{8'd7, 8'd1, 8'd10, 8'd255};
    logic [W-1:0] eq, er;
    logic ez;
    int lat, nb;
    for (int i = 0; i < 4; i++) begin
      ref_div(at[i], bt[i], eq, er, ez);
      issue(at[i], bt[i]);
      wait_done(lat, nb);
      n_tests++;
      if (lat != W || nb != W) begin
        n_fail++;
        $display("FAIL known_latency[%0d]: done after %0d cycles with %0d busy, need %0d and %0d", i, lat, nb, W, W);
      end
      n_tests++;
      if (bus.quotient !== eq || bus.remainder !== er || bus.div_by_zero !== ez) begin
        n_fail++;
        $display("FAIL known_result[%0d] %0d/%0d: q=%0d r=%0d dbz=%b, need q=%0d r=%0d dbz=%b",
                 i, at[i], bt[i], bus.quotient, bus.remainder, bus.div_by_zero, eq, er, ez);
      end
      tick();
      n_tests++;
      if (bus.done !== 1'b0 || bus.quotient !== eq || bus.remainder !== er) begin
        n_fail++;
        $display("FAIL known_hold[%0d]: done=%b q=%0d r=%0d, need done=0 q=%0d r=%0d",
                 i, bus.done, bus.quotient, bus.remainder, eq, er);
      end
    end
  endtask

  task automatic test_div_zero();
    int lat, nb;
    issue(8'd37, 8'd0);
    wait_done(lat, nb);
    n_tests++;
    if (lat != 0 || nb != 0) begin
      n_fail++;
      $display("FAIL dbz_timing: done after %0d cycles with %0d busy, need 0 and 0", lat, nb);
    end
    n_tests++;
    if (bus.quotient !== MAXV || bus.remainder !== 8'd37 || bus.div_by_zero !== 1'b1) begin
      n_fail++;
      $display("FAIL dbz_result: q=%0d r=%0d dbz=%b, need q=%0d r=37 dbz=1",
               bus.quotient, bus.remainder, bus.div_by_zero, MAXV);
    end
    tick();
    n_tests++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL dbz_after: done=%b busy=%b, need 0 0", bus.done, bus.busy);
    end
  endtask

  task automatic test_ignore_start();
    int lat, nb;
    bit seen;
    issue(8'd200, 8'd6);
    tick(); tick();
    bus.start = 1'b1; bus.dividend = 8'd9; bus.divisor = 8'd3;
    tick();
    bus.start = 1'b0;
    wait_done(lat, nb);
    n_tests++;
    if (lat + 3 != W) begin
      n_fail++;
      $display("FAIL ignore_latency: done %0d cycles after accept, need %0d", lat + 3, W);
    end
    n_tests++;
    if (bus.quotient !== 8'd33 || bus.remainder !== 8'd2 || bus.div_by_zero !== 1'b0) begin
      n_fail++;
      $display("FAIL ignore_result: q=%0d r=%0d dbz=%b, need q=33 r=2 dbz=0",
               bus.quotient, bus.remainder, bus.div_by_zero);
    end
    seen = 1'b0;
    repeat (2*W) begin
      tick();
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) seen = 1'b1;
    end
    n_tests++;
    if (seen || bus.quotient !== 8'd33 || bus.remainder !== 8'd2) begin
      n_fail++;
      $display("FAIL ignore_no_second_op: activity=%b q=%0d r=%0d, need activity=0 q=33 r=2",
               seen, bus.quotient, bus.remainder);
    end
  endtask

  task automatic test_reset_mid_run();
    int lat, nb;
    bit seen;
    issue(8'd77, 8'd5);
    tick(); tick(); tick();
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero} !== '0) begin
      n_fail++;
      $display("FAIL midrun_reset: busy=%b done=%b q=%0d r=%0d dbz=%b, all must be 0",
               bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero);
    end
    tick(); tick();
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (2*W) begin
      tick();
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) seen = 1'b1;
    end
    n_tests++;
    if (seen) begin
      n_fail++;
      $display("FAIL midrun_no_done: activity=1 after aborted op, need 0");
    end
    issue(8'd77, 8'd5);
    wait_done(lat, nb);
    n_tests++;
    if (lat != W || bus.quotient !== 8'd15 || bus.remainder !== 8'd2) begin
      n_fail++;
      $display("FAIL midrun_rerun: lat=%0d q=%0d r=%0d, need lat=%0d q=15 r=2",
               lat, bus.quotient, bus.remainder, W);
    end
    tick();
  endtask

  // start held high: each new pair is presented right after done and accepted two edges later.
  task automatic test_random_sweep(input int nops);
    logic [W-1:0] a, b, eq, er;
    logic ez;
    int cyc, sel;
    bus.start = 1'b1;
    for (int k = 0; k < nops; k++) begin
      sel = $urandom_range(0, 9);
      a = W'($urandom); b = W'($urandom);
      if (sel == 0) a = '0;
      if (sel == 1) a = MAXV;
      if (sel == 2) b = '0;
      if (sel == 3) b = MAXV;
      if (sel == 4) b = 8'd1;
      bus.dividend = a; bus.divisor = b;
      ref_div(a, b, eq, er, ez);
      cyc = 0;
      do begin
        tick();
        cyc++;
      end while (bus.done !== 1'b1 && cyc < 4*W);
      n_tests++;
      if (bus.quotient !== eq || bus.remainder !== er || bus.div_by_zero !== ez) begin
        n_fail++;
        $display("FAIL sweep_result[%0d] %0d/%0d: q=%0d r=%0d dbz=%b, need q=%0d r=%0d dbz=%b",
                 k, a, b, bus.quotient, bus.remainder, bus.div_by_zero, eq, er, ez);
      end
      if (b != '0) begin
        n_tests++;
        if (int'(bus.quotient) * int'(b) + int'(bus.remainder) != int'(a) || bus.remainder >= b) begin
          n_fail++;
          $display("FAIL sweep_identity[%0d] %0d/%0d: q=%0d r=%0d", k, a, b, bus.quotient, bus.remainder);
        end
      end
      if (k > 0) begin
        n_tests++;
        if (cyc != ((b != '0) ? W + 2 : 2)) begin
          n_fail++;
          $display("FAIL sweep_spacing[%0d] divisor=%0d: %0d cycles between done pulses, need %0d",
                   k, b, cyc, (b != '0) ? W + 2 : 2);
        end
      end
    end
    bus.start = 1'b0;
    tick(); tick();
  endtask

  initial begin
    test_reset();
    test_known();
    test_div_zero();
    test_ignore_start();
    test_reset_mid_run();
    test_random_sweep(3000);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
